// File: rtl/textbuffer_if.sv
// Byte-stream handshake into the text buffer: the producer drives data/valid,
// and the buffer answers with ready.
interface textbuffer_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/textbuffer.sv
// Character buffer ahead of the textbox renderer. Incoming bytes edit a shadow
// line, and that line is copied to the display array once per frame, so a half-written line is never shown.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for bytes; edits shadow and commits on frame
// S_CLEAR | wipes one shadow cell per cycle; input stalled
module textbuffer #(
    parameter int         COLS      = 8,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    textbuffer_if.slave              in_if,
    input  logic                     frame_i,
    output logic [7:0]               chars_o [COLS],
    output logic [$clog2(COLS)-1:0]  cursor_o,
    output logic                     dirty_o
);

    localparam int CW = $clog2(COLS);
    typedef logic [CW-1:0] idx_t;
    localparam idx_t LAST = idx_t'(COLS - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t     state_q;
    logic [7:0] shadow_q [COLS];
    logic [7:0] chars_q  [COLS];
    idx_t       cursor_q;
    idx_t       clr_idx_q;
    logic       dirty_q;
    logic       commit_pending_q;
    logic       ready_q;

    idx_t       cursor_fwd_d;
    idx_t       cursor_back_d;
    logic       accept;
    logic       printable;
    logic       commit;

    // Explicit wrap keeps non-power-of-two widths correct.
    always_comb begin
        cursor_fwd_d  = (cursor_q == LAST) ? '0 : cursor_q + idx_t'(1);
        cursor_back_d = cursor_q - idx_t'(1);
        accept        = in_if.valid && ready_q;
        printable     = (in_if.data >= 8'h20) && (in_if.data <= 8'h7E);
        commit        = (state_q == S_IDLE) && ((frame_i && dirty_q) || commit_pending_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < COLS; i++) begin
                shadow_q[i] <= FILL_CHAR;
                chars_q[i]  <= FILL_CHAR;
            end
            state_q          <= S_IDLE;
            cursor_q         <= '0;
            clr_idx_q        <= '0;
            dirty_q          <= 1'b0;
            commit_pending_q <= 1'b0;
            ready_q          <= 1'b1;
        end else begin
            // The commit samples shadow before this edge's write; a byte
            // accepted on the same edge re-sets dirty below.
            if (commit) begin
                chars_q          <= shadow_q;
                dirty_q          <= 1'b0;
                commit_pending_q <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            shadow_q[cursor_q] <= in_if.data;
                            cursor_q           <= cursor_fwd_d;
                            dirty_q            <= 1'b1;
                        end else if (in_if.data == 8'h08) begin
                            if (cursor_q != '0) begin
                                shadow_q[cursor_back_d] <= FILL_CHAR;
                                cursor_q                <= cursor_back_d;
                                dirty_q                 <= 1'b1;
                            end
                        end else if (in_if.data == 8'h0D) begin
                            cursor_q <= '0;
                        end else if (in_if.data == 8'h0C) begin
                            cursor_q  <= '0;
                            clr_idx_q <= '0;
                            ready_q   <= 1'b0;
                            state_q   <= S_CLEAR;
                        end
                    end
                end
                S_CLEAR: begin
                    shadow_q[clr_idx_q] <= FILL_CHAR;
                    if (frame_i) begin
                        commit_pending_q <= 1'b1;
                    end
                    if (clr_idx_q == LAST) begin
                        dirty_q <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        clr_idx_q <= clr_idx_q + idx_t'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign chars_o     = chars_q;
    assign cursor_o    = cursor_q;
    assign dirty_o     = dirty_q;
    assign in_if.ready = ready_q;

endmodule

// File: tb/tb_textbuffer.sv
// Self-checking bench for textbuffer: directed scenarios plus a randomized
// byte/frame stream compared against a behavioural model of the buffer.
module tb_textbuffer;

    localparam int         COLS = 8;
    localparam int         CW   = $clog2(COLS);
    localparam logic [7:0] FILL = 8'h20;
    localparam logic [8*COLS-1:0] ALL_FILL = {COLS{FILL}};

    logic          clk_i   = 1'b0;
    logic          reset_i = 1'b0;
    logic          frame_i = 1'b0;
    logic [7:0]    chars [COLS];
    logic [CW-1:0] cursor;
    logic          dirty;

    int n_pass  = 0;
    int n_total = 0;

    textbuffer_if bus ();

    textbuffer #(.COLS(COLS), .FILL_CHAR(FILL)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .in_if    (bus),
        .frame_i  (frame_i),
        .chars_o  (chars),
        .cursor_o (cursor),
        .dirty_o  (dirty)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model: one call per clock edge.
    logic [7:0] m_shadow [COLS];
    logic [7:0] m_chars  [COLS];
    int         m_cur;
    bit         m_dirty;
    bit         m_pending;
    int         m_busy;

    function automatic void mdl_reset();
        for (int i = 0; i < COLS; i++) begin
            m_shadow[i] = FILL;
            m_chars[i]  = FILL;
        end
        m_cur = 0; m_dirty = 0; m_pending = 0; m_busy = 0;
    endfunction

    function automatic void mdl_tick(input bit v, input logic [7:0] d, input bit f);
        if (m_busy > 0) begin
            if (f) m_pending = 1;
            m_busy--;
            if (m_busy == 0) m_dirty = 1;
            return;
        end
        if (m_pending || (f && m_dirty)) begin
            m_chars   = m_shadow;
            m_dirty   = 0;
            m_pending = 0;
        end
        if (!v) return;
        if (d >= 8'h20 && d <= 8'h7E) begin
            m_shadow[m_cur] = d;
            m_cur   = (m_cur + 1) % COLS;
            m_dirty = 1;
        end else if (d == 8'h08) begin
            if (m_cur != 0) begin
                m_cur = m_cur - 1;
                m_shadow[m_cur] = FILL;
                m_dirty = 1;
            end
        end else if (d == 8'h0D) begin
            m_cur = 0;
        end else if (d == 8'h0C) begin
            m_cur = 0;
            for (int i = 0; i < COLS; i++) m_shadow[i] = FILL;
            m_busy = COLS;
        end
    endfunction

    function automatic logic [8*COLS-1:0] pack_dut();
        logic [8*COLS-1:0] v;
        for (int i = 0; i < COLS; i++) v[8*(COLS-1-i) +: 8] = chars[i];
        return v;
    endfunction

    function automatic logic [8*COLS-1:0] pack_mdl();
        logic [8*COLS-1:0] v;
        for (int i = 0; i < COLS; i++) v[8*(COLS-1-i) +: 8] = m_chars[i];
        return v;
    endfunction

    // Inputs change on the falling edge; outputs are observed on the next falling edge.
    task automatic tick(input bit v, input logic [7:0] d, input bit f);
        bus.valid = v;
        bus.data  = d;
        frame_i   = f;
        mdl_tick(v, d, f);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        reset_i   = 1'b1;
        bus.valid = 1'b0;
        frame_i   = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
        mdl_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (pack_dut() !== ALL_FILL) $display("FAIL reset_chars got=%h exp=%h", pack_dut(), ALL_FILL); else n_pass++;
        n_total++; if (cursor !== '0) $display("FAIL reset_cursor got=%0d exp=0", cursor); else n_pass++;
        n_total++; if (dirty !== 1'b0) $display("FAIL reset_dirty got=%b exp=0", dirty); else n_pass++;
        n_total++; if (bus.ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.ready); else n_pass++;
    endtask

    task automatic test_basic_write();
        do_reset();
        tick(1, "H", 0);
        tick(1, "I", 0);
        tick(0, 8'h00, 0);
        n_total++; if (pack_dut() !== ALL_FILL) $display("FAIL basic_precommit got=%h exp=%h", pack_dut(), ALL_FILL); else n_pass++;
        tick(0, 8'h00, 1);
        n_total++; if (pack_dut() !== 64'h4849_2020_2020_2020) $display("FAIL basic_commit got=%h exp=%h", pack_dut(), 64'h4849_2020_2020_2020); else n_pass++;
        n_total++; if (cursor !== 3'd2) $display("FAIL basic_cursor got=%0d exp=2", cursor); else n_pass++;
        n_total++; if (dirty !== 1'b0) $display("FAIL basic_dirty got=%b exp=0", dirty); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 9; i++) tick(1, 8'h41 + 8'(i), 0);
        tick(0, 8'h00, 1);
        n_total++; if (pack_dut() !== 64'h4942_4344_4546_4748) $display("FAIL wrap_chars got=%h exp=%h", pack_dut(), 64'h4942_4344_4546_4748); else n_pass++;
        n_total++; if (cursor !== 3'd1) $display("FAIL wrap_cursor got=%0d exp=1", cursor); else n_pass++;
    endtask

    task automatic test_backspace_cr();
        do_reset();
        tick(1, "A", 0);
        tick(1, "B", 0);
        repeat (3) tick(1, 8'h08, 0);
        tick(0, 8'h00, 1);
        n_total++; if (pack_dut() !== ALL_FILL) $display("FAIL bs_chars got=%h exp=%h", pack_dut(), ALL_FILL); else n_pass++;
        n_total++; if (cursor !== 3'd0) $display("FAIL bs_cursor got=%0d exp=0", cursor); else n_pass++;
        tick(1, "X", 0);
        tick(1, "Y", 0);
        tick(1, "Z", 0);
        tick(1, 8'h0D, 0);
        n_total++; if (cursor !== 3'd0) $display("FAIL cr_cursor got=%0d exp=0", cursor); else n_pass++;
        tick(1, "Q", 0);
        tick(0, 8'h00, 1);
        n_total++; if (pack_dut() !== 64'h5159_5A20_2020_2020) $display("FAIL cr_chars got=%h exp=%h", pack_dut(), 64'h5159_5A20_2020_2020); else n_pass++;
        n_total++; if (cursor !== 3'd1) $display("FAIL cr_cursor_after got=%0d exp=1", cursor); else n_pass++;
    endtask

    task automatic test_clear_deferred();
        int low;
        do_reset();
        for (int i = 0; i < COLS; i++) tick(1, 8'h41 + 8'(i), 0);
        tick(0, 8'h00, 1);
        tick(1, 8'h0C, 0);
        low = 0;
        for (int i = 0; i < 20 && bus.ready !== 1'b1; i++) begin
            low++;
            n_total++; if (pack_dut() !== 64'h4142_4344_4546_4748) $display("FAIL clear_chars_held cyc=%0d got=%h exp=%h", i, pack_dut(), 64'h4142_4344_4546_4748); else n_pass++;
            tick(1, "X", i == 2);
        end
        n_total++; if (low != COLS) $display("FAIL clear_ready_low got=%0d exp=%0d", low, COLS); else n_pass++;
        tick(0, 8'h00, 0);
        n_total++; if (pack_dut() !== ALL_FILL) $display("FAIL clear_deferred_commit got=%h exp=%h", pack_dut(), ALL_FILL); else n_pass++;
        n_total++; if (dirty !== 1'b0) $display("FAIL clear_dirty got=%b exp=0", dirty); else n_pass++;
        n_total++; if (cursor !== 3'd0) $display("FAIL clear_cursor got=%0d exp=0", cursor); else n_pass++;
    endtask

    task automatic test_tear_free();
        do_reset();
        tick(1, "A", 0);
        tick(1, "Z", 1);
        n_total++; if (pack_dut() !== 64'h4120_2020_2020_2020) $display("FAIL tear_excl got=%h exp=%h", pack_dut(), 64'h4120_2020_2020_2020); else n_pass++;
        n_total++; if (dirty !== 1'b1) $display("FAIL tear_dirty got=%b exp=1", dirty); else n_pass++;
        tick(0, 8'h00, 1);
        n_total++; if (pack_dut() !== 64'h415A_2020_2020_2020) $display("FAIL tear_next got=%h exp=%h", pack_dut(), 64'h415A_2020_2020_2020); else n_pass++;
        tick(0, 8'h00, 1);
        n_total++; if (pack_dut() !== 64'h415A_2020_2020_2020) $display("FAIL tear_idle got=%h exp=%h", pack_dut(), 64'h415A_2020_2020_2020); else n_pass++;
        n_total++; if (dirty !== 1'b0) $display("FAIL tear_idle_dirty got=%b exp=0", dirty); else n_pass++;
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        tick(1, "A", 0);
        tick(1, "B", 0);
        tick(1, 8'h0C, 0);
        tick(0, 8'h00, 0);
        tick(0, 8'h00, 1);
        tick(0, 8'h00, 0);
        do_reset();
        n_total++; if (bus.ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", bus.ready); else n_pass++;
        n_total++; if (pack_dut() !== ALL_FILL) $display("FAIL midrst_chars got=%h exp=%h", pack_dut(), ALL_FILL); else n_pass++;
        n_total++; if (dirty !== 1'b0) $display("FAIL midrst_dirty got=%b exp=0", dirty); else n_pass++;
        tick(1, 8'h07, 0);
        n_total++; if (cursor !== 3'd0) $display("FAIL bel_cursor got=%0d exp=0", cursor); else n_pass++;
        n_total++; if (dirty !== 1'b0) $display("FAIL bel_dirty got=%b exp=0", dirty); else n_pass++;
        tick(1, "K", 0);
        tick(1, 8'h07, 0);
        n_total++; if (cursor !== 3'd1) $display("FAIL bel2_cursor got=%0d exp=1", cursor); else n_pass++;
        n_total++; if (dirty !== 1'b1) $display("FAIL bel2_dirty got=%b exp=1", dirty); else n_pass++;
        n_total++; if (pack_dut() !== ALL_FILL) $display("FAIL midrst_no_pending got=%h exp=%h", pack_dut(), ALL_FILL); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] d;
        int         r;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 15);
            case (r)
                0:       d = 8'h08;
                1:       d = 8'h0D;
                2:       d = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h7F;
                3:       d = 8'($urandom_range(0, 31));
                default: d = 8'($urandom_range(32, 126));
            endcase
            tick($urandom_range(0, 3) != 0, d, $urandom_range(0, 5) == 0);
            n_total++; if (bus.ready !== (m_busy == 0)) $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, bus.ready, (m_busy == 0)); else n_pass++;
            n_total++; if (cursor !== CW'(m_cur)) $display("FAIL rnd_cursor n=%0d got=%0d exp=%0d", n, cursor, m_cur); else n_pass++;
            n_total++; if (dirty !== m_dirty) $display("FAIL rnd_dirty n=%0d got=%b exp=%b", n, dirty, m_dirty); else n_pass++;
            n_total++; if (pack_dut() !== pack_mdl()) $display("FAIL rnd_chars n=%0d got=%h exp=%h", n, pack_dut(), pack_mdl()); else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid = 1'b0;
        bus.data  = 8'h00;
        mdl_reset();
        @(negedge clk_i);
        test_reset();
        test_basic_write();
        test_wrap();
        test_backspace_cr();
        test_clear_deferred();
        test_tear_free();
        test_reset_mid_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/textbuffer.md
# textbuffer

Character-buffer stage upstream of the textbox renderer. It accepts a byte stream over a valid/ready handshake and interprets printable ASCII and a small set of control codes into a shadow buffer of COLS cells. Once per frame it commits the shadow buffer to the `chars` array that drives textbox, so the display never shows a half-written line.

## Interface

**Parameters**
- `COLS`, default 8: number of character cells. Must match the textbox `COLS`. Range 2..256.
- `FILL_CHAR`, default 8'h20: value used for reset, clear and backspace erase.

**Ports**
- `clk`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-high.
- `in_data`, in, 8: incoming character byte.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: the block can accept a byte this cycle.
- `frame`, in, 1: one-cycle pulse at the start of vertical blanking. Connect to the window `frame` output.
- `chars`, out, 8 × [0:COLS-1]: committed display buffer, wired to textbox `chars`.
- `cursor`, out, $clog2(COLS): next cell to be written.
- `dirty`, out, 1: the shadow buffer differs from the last commit.

## Operation

- A byte is accepted on any rising edge where `in_valid && in_ready`.
- States:
  - **IDLE**: `in_ready` = 1.
  - **CLEAR**: `in_ready` = 0.
- Accepted byte handling in IDLE:
  - **0x20–0x7E**: `shadow[cursor] <= byte`. `cursor` increments and wraps from COLS-1 to 0. `dirty` is set.
  - **0x08 (BS)**: if `cursor` = 0, no-op with no wrap. Otherwise `cursor <= cursor-1`, `shadow[cursor-1] <= FILL_CHAR`, and `dirty` is set.
  - **0x0D (CR)**: `cursor <= 0`. Shadow is unchanged and `dirty` is unaffected.
  - **0x0C (FF)**: `cursor <= 0`, `clr_idx <= 0`, transition to CLEAR.
  - **Any other value**: consumed and discarded with no effect.
- CLEAR:
  - Each cycle, `shadow[clr_idx] <= FILL_CHAR` and `clr_idx` increments.
  - After writing cell COLS-1: set `dirty`, return to IDLE.
  - CLEAR lasts exactly COLS cycles. `in_ready` is low throughout.
- Commit:
  - On an edge where `frame` = 1, state = IDLE and `dirty` = 1: `chars <= shadow` (all cells in one cycle) and clear `dirty`.
  - If `frame` = 1 while in CLEAR: set an internal `commit_pending`. The commit happens on the first IDLE cycle after CLEAR completes, then `commit_pending` clears.
  - `frame` with `dirty` = 0 does nothing.
- Arithmetic:
  - `cursor` and `clr_idx` are $clog2(COLS) bits.
  - For non-power-of-two COLS, wrap is explicit (compare to COLS-1), never modulo-by-width.

## Timing

- **Reset values** (take effect on the edge where `reset` = 1; override all other activity, including mid-CLEAR and pending commit):
  - every `shadow` and `chars` cell = FILL_CHAR
  - `cursor` = 0
  - `dirty` = 0
  - `in_ready` = 1
  - state = IDLE
  - `commit_pending` = 0
- **Write latency**: a byte accepted at edge N is in `shadow` after edge N. With `frame` asserted at edge M > N, it appears on `chars` after edge M, i.e. 1 cycle after the frame pulse.
- **Simultaneous accept and frame on the same edge**: the commit captures the shadow contents *before* that edge's write. The new byte stays dirty and commits on the next frame.
- **FF accepted at edge N**: `in_ready` is low for cycles N+1..N+COLS and high again at N+COLS+1.
- **`in_ready`**: registered from state, with no combinational path from `in_valid`. Upstream may hold `in_valid` high indefinitely.
- **`chars`**: changes only on commit or reset edges, always within blanking when `frame` is sourced from the window.

## Test plan

1. **Reset and basic write** (COLS=8): after reset, stream "HI" then pulse `frame`.
   - Before the pulse: `chars` = eight 0x20.
   - One cycle after the pulse: `chars[0..1]` = 0x48, 0x49; the rest 0x20; `cursor` = 2; `dirty` = 0.
2. **Wrap-around**: write 9 bytes 'A'..'I' then commit.
   - `chars[0]` = 'I', `chars[1..7]` = 'B'..'H', `cursor` = 1.
3. **Backspace and CR**:
   - "AB", BS, BS, BS, commit → all 0x20, `cursor` = 0.
   - "XYZ", CR, 'Q' → `chars[0..2]` = "QYZ", `cursor` = 1.
4. **Clear with deferred commit**: fill 8 cells, send FF, pulse `frame` 3 cycles later.
   - `in_ready` is low for exactly 8 cycles.
   - `chars` is unchanged during CLEAR.
   - All cells become 0x20 one cycle after CLEAR ends, with no second frame needed.
5. **Tear-free edge**: assert `frame` on the same edge 'Z' is accepted.
   - That commit excludes 'Z'.
   - The next `frame` shows 'Z'.
   - A subsequent `frame` with no writes leaves `chars` unchanged and `dirty` = 0.
6. **Reset mid-CLEAR**: assert `reset` during cycle 4 of CLEAR.
   - Next cycle: state IDLE, `in_ready` = 1, all cells 0x20, no pending commit fires.
   - Non-printable 0x07 is later accepted and ignored (`cursor` and `dirty` unchanged).
